// File: rtl/cgralib_sipo_window_if.sv
// Handshake bundle for cgralib_sipo_window: pixel stream in, window stream out.
// master = producer/consumer side (testbench or surrounding fabric),
// slave  = the window register itself.
interface cgralib_sipo_window_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 3
);
    // pixel input side
    logic                          valid_in;
    logic                          ready_in;
    logic [DATA_WIDTH-1:0]         in_data;

    // window output side
    logic                          valid_out;
    logic                          ready_out;
    logic [DEPTH*DATA_WIDTH-1:0]   out_data;
    logic                          last_out;

    modport master (
        output valid_in,
        output in_data,
        output ready_out,
        input  ready_in,
        input  valid_out,
        input  out_data,
        input  last_out
    );

    modport slave (
        input  valid_in,
        input  in_data,
        input  ready_out,
        output ready_in,
        output valid_out,
        output out_data,
        output last_out
    );
endinterface

// File: rtl/cgralib_sipo_window.sv
// cgralib_sipo_window: parametrised serial-in parallel-out window register.
// Accepts one pixel per handshake and presents the newest DEPTH pixels of the
// current row as parallel taps (tap 0 = newest), emitting every STRIDE-th full
// window of a row with ready/valid backpressure. History clears at row end.
// Optional build macro: CGRALIB_SIPO_PAD_EN (zero-padded "same" windows: taps
// clear at row start and the first pixel of a row already forms a window).
module cgralib_sipo_window #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned ROW_LEN    = 64,
    parameter int unsigned STRIDE     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cgralib_sipo_window_if.slave bus
);

    localparam int unsigned COL_W   = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int unsigned FILL_W  = $clog2(DEPTH + 1);
    localparam int unsigned PHASE_W = $clog2(STRIDE) + 1;

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(ROW_LEN - 1);
    localparam logic [COL_W-1:0]   COL_ONE    = COL_W'(1);
    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0]  FILL_ONE   = FILL_W'(1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(STRIDE - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
`ifdef CGRALIB_SIPO_PAD_EN
    // Padded rows start one pixel short of full: the implicit zeros count.
    localparam logic [FILL_W-1:0]  FILL_INIT  = FILL_W'(DEPTH - 1);
`else
    localparam logic [FILL_W-1:0]  FILL_INIT  = '0;
`endif

    // Reject parameter sets that cannot produce a sensible window stream.
    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("cgralib_sipo_window: DEPTH must be >= 1");
        end
        if (STRIDE < 1) begin : g_bad_stride
            $error("cgralib_sipo_window: STRIDE must be >= 1");
        end
`ifndef CGRALIB_SIPO_PAD_EN
        if (ROW_LEN < DEPTH) begin : g_bad_row_len
            $error("cgralib_sipo_window: ROW_LEN must be >= DEPTH");
        end
`endif
    endgenerate

    logic [DATA_WIDTH-1:0]       taps    [DEPTH];
    logic [DATA_WIDTH-1:0]       shifted [DEPTH];
    logic [COL_W-1:0]            col;
    logic [FILL_W-1:0]           fill;
    logic [FILL_W-1:0]           fill_n;
    logic [PHASE_W-1:0]          phase;
    logic                        ready;
    logic                        push;
    logic                        full_n;
    logic                        row_end;
    logic                        emit;
    logic                        valid_q;
    logic                        last_q;
    logic [DEPTH*DATA_WIDTH-1:0] out_pack;

    // Handshake qualifiers and the emit decision for the current cycle.
    always_comb begin
        ready   = !valid_q || bus.ready_out;
        push    = bus.valid_in && ready;
        fill_n  = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_ONE;
        full_n  = (fill_n == FILL_FULL);
        row_end = (col == COL_LAST);
        emit    = push && full_n && (phase == '0);
    end

    // Tap contents after a push: newest pixel enters at tap 0.
    always_comb begin
        shifted[0] = bus.in_data;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            shifted[k] = taps[k-1];
        end
    end

    // Column, fill and stride-phase bookkeeping; all three restart at row end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            fill  <= FILL_INIT;
            phase <= '0;
        end else if (push) begin
            if (row_end) begin
                col   <= '0;
                fill  <= FILL_INIT;
                phase <= '0;
            end else begin
                col  <= col + COL_ONE;
                fill <= fill_n;
                if (full_n) begin
                    phase <= (phase == PHASE_LAST) ? '0 : phase + PHASE_ONE;
                end
            end
        end
    end

    // Tap shift register, advancing on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                taps[k] <= '0;
            end
        end else if (push) begin
`ifdef CGRALIB_SIPO_PAD_EN
            for (int unsigned k = 0; k < DEPTH; k++) begin
                taps[k] <= row_end ? '0 : shifted[k];
            end
`else
            for (int unsigned k = 0; k < DEPTH; k++) begin
                taps[k] <= shifted[k];
            end
`endif
        end
    end

`ifdef CGRALIB_SIPO_PAD_EN
    logic [DATA_WIDTH-1:0] win_q [DEPTH];

    // Padded taps are wiped at row end, so the emitted window is captured
    // separately to keep the row's final window visible while it is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                win_q[k] <= '0;
            end
        end else if (emit) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                win_q[k] <= shifted[k];
            end
        end
    end

    // Flatten the captured window onto the output bus.
    always_comb begin
        out_pack = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            out_pack[k*DATA_WIDTH +: DATA_WIDTH] = win_q[k];
        end
    end
`else
    // Flatten the live taps onto the output bus; they are frozen while stalled.
    always_comb begin
        out_pack = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            out_pack[k*DATA_WIDTH +: DATA_WIDTH] = taps[k];
        end
    end
`endif

    // Output valid/last: set by an emitting push, cleared once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (emit) begin
            valid_q <= 1'b1;
            last_q  <= row_end;
        end else if (bus.ready_out) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign bus.ready_in  = ready;
    assign bus.valid_out = valid_q;
    assign bus.last_out  = last_q;
    assign bus.out_data  = out_pack;

endmodule
